// File: rtl/bldc_quadrature_generator_pkg.sv
// Shared definitions for the BLDC quadrature generator: quadrature codes,
// FSM state encoding and the one-step sequence function.
package bldc_quadrature_generator_pkg;

  localparam int DEF_COUNT_WIDTH  = 15;
  localparam int DEF_PERIOD_WIDTH = 16;

  // Quadrature codes {A,B}, shared with the encoder counter.
  localparam logic [1:0] STEP_0 = 2'b00;
  localparam logic [1:0] STEP_1 = 2'b01;
  localparam logic [1:0] STEP_2 = 2'b10;
  localparam logic [1:0] STEP_3 = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } gen_state_t;

  // Next quadrature code. dir=0 walks up (00->01->11->10), dir=1 walks down.
  // Only one bit changes per call, so the output is always Gray-valid.
  function automatic logic [1:0] next_step(input logic [1:0] code, input logic dir);
    logic [1:0] res;
    res = STEP_0;
    case (code)
      STEP_0:  res = dir ? STEP_2 : STEP_1;
      STEP_1:  res = dir ? STEP_0 : STEP_3;
      STEP_3:  res = dir ? STEP_1 : STEP_2;
      STEP_2:  res = dir ? STEP_3 : STEP_0;
      default: res = STEP_0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bldc_quadrature_generator_timer.sv
// Reloadable edge-interval down-counter. tick is high for the one clock in
// which the count sits at 1 while running; the count reloads on that tick.
module quad_step_timer
  import bldc_quadrature_generator_pkg::*;
#(
  parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    run,
  output logic                    tick
);

  localparam logic [PERIOD_WIDTH-1:0] ONE  = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PERIOD_WIDTH-1:0] ZERO = {PERIOD_WIDTH{1'b0}};

  logic [PERIOD_WIDTH-1:0] r_count;

  assign tick = run && (r_count == ONE);

  // Count down while running; load/reload from the period input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= ZERO;
    end else if (load) begin
      r_count <= period;
    end else if (tick) begin
      r_count <= period;
    end else if (run && (r_count != ZERO)) begin
      r_count <= r_count - ONE;
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/bldc_quadrature_generator.sv
// Quadrature waveform generator: turns signed step commands into {A,B}
// encoder edges at a programmable interval and tracks the signed position
// a correct decoder would accumulate from those edges.
module bldc_quadrature_generator
  import bldc_quadrature_generator_pkg::*;
#(
  parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH,
  parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [COUNT_WIDTH-1:0]  cmd_steps,
  input  logic [PERIOD_WIDTH-1:0] cmd_period,
  input  logic                    abort,
  input  logic                    pos_clear,
  output logic [1:0]              enc,
  output logic                    busy,
  output logic                    done,
  output logic [COUNT_WIDTH-1:0]  position
);

  localparam logic [COUNT_WIDTH-1:0]  C_ZERO = {COUNT_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0]  C_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0]  C_MONE = {COUNT_WIDTH{1'b1}};
  localparam logic [PERIOD_WIDTH-1:0] P_ZERO = {PERIOD_WIDTH{1'b0}};
  localparam logic [PERIOD_WIDTH-1:0] P_ONE  = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

  gen_state_t r_state;
  gen_state_t w_state_next;

  logic                    r_dir;
  logic [COUNT_WIDTH-1:0]  r_remaining;
  logic [PERIOD_WIDTH-1:0] r_period;
  logic [1:0]              r_enc;
  logic [COUNT_WIDTH-1:0]  r_position;
  logic                    r_done;

  logic                    w_done_next;
  logic                    w_accept;
  logic                    w_cmd_zero;
  logic [COUNT_WIDTH-1:0]  w_steps_abs;
  logic [PERIOD_WIDTH-1:0] w_period_eff;
  logic                    w_timer_load;
  logic [PERIOD_WIDTH-1:0] w_timer_period;
  logic                    w_run;
  logic                    w_tick;
  logic                    w_edge;
  logic                    w_last;

  // Magnitude as unsigned: the most negative command maps to 2^(W-1) exactly.
  assign w_steps_abs  = cmd_steps[COUNT_WIDTH-1] ? (~cmd_steps + C_ONE) : cmd_steps;
  assign w_period_eff = (cmd_period == P_ZERO) ? P_ONE : cmd_period;
  assign w_cmd_zero   = (cmd_steps == C_ZERO);
  assign w_accept     = cmd_valid && (r_state == ST_IDLE);
  assign w_run        = (r_state == ST_RUN);
  // Abort beats a due edge, so an aborted cycle never moves enc.
  assign w_edge       = w_run && w_tick && !abort;
  assign w_last       = w_edge && (r_remaining == C_ONE);

  assign w_timer_load   = w_accept && !w_cmd_zero;
  assign w_timer_period = w_timer_load ? w_period_eff : r_period;

  quad_step_timer #(
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (w_timer_load),
    .period (w_timer_period),
    .run    (w_run),
    .tick   (w_tick)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and completion pulse.
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_cmd_zero) begin
          w_done_next = 1'b1;
        end else if (w_accept) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_next = ST_IDLE;
        end else if (w_last) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Command latch and remaining-edge counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dir       <= 1'b0;
      r_remaining <= C_ZERO;
      r_period    <= P_ONE;
    end else if (w_accept) begin
      r_dir       <= cmd_steps[COUNT_WIDTH-1];
      r_remaining <= w_steps_abs;
      r_period    <= w_period_eff;
    end else if (w_edge) begin
      r_remaining <= r_remaining - C_ONE;
    end else begin
      r_remaining <= r_remaining;
    end
  end

  // Quadrature output: one Gray step per emitted edge, held while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enc <= STEP_0;
    end else if (w_edge) begin
      r_enc <= next_step(r_enc, r_dir);
    end else begin
      r_enc <= r_enc;
    end
  end

  // Signed position, wrapping; a clear overrides a coincident edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_position <= C_ZERO;
    end else if (pos_clear) begin
      r_position <= C_ZERO;
    end else if (w_edge) begin
      r_position <= r_position + (r_dir ? C_MONE : C_ONE);
    end else begin
      r_position <= r_position;
    end
  end

  // Registered completion pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_next;
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_RUN);
  assign enc       = r_enc;
  assign done      = r_done;
  assign position  = r_position;

endmodule

// File: tb/tb_bldc_quadrature_generator.sv
// Self-checking bench for bldc_quadrature_generator. Expected behaviour comes
// from a timeline model: edges emitted = min(elapsed/period, limit), enc is a
// lookup in the Gray cycle, position is an integer sum.
module tb_bldc_quadrature_generator;

  localparam int CW = 15;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_steps;
  logic [PW-1:0] cmd_period;
  logic          abort;
  logic          pos_clear;
  logic [1:0]    enc;
  logic          busy;
  logic          done;
  logic [CW-1:0] position;

  int total = 0;
  int bad   = 0;
  int m_pos = 0;
  int m_ph  = 0;

  logic [1:0] gray_tab [4];

  bldc_quadrature_generator #(
    .COUNT_WIDTH (CW),
    .PERIOD_WIDTH(PW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_steps (cmd_steps),
    .cmd_period(cmd_period),
    .abort     (abort),
    .pos_clear (pos_clear),
    .enc       (enc),
    .busy      (busy),
    .done      (done),
    .position  (position)
  );

  always #5 clk = ~clk;

  function automatic int gidx(input logic [1:0] c);
    int r;
    case (c)
      2'b00:   r = 0;
      2'b01:   r = 1;
      2'b11:   r = 2;
      default: r = 3;
    endcase
    return r;
  endfunction

  // Issue one command at the current negedge and check every cycle until it
  // ends (done cycle or abort). Leaves the bench at that final negedge.
  task automatic run_cmd(input int steps, input int period, input int abort_e,
                         input int clear_e, input bit junk);
    int n, p, sgn, tend, edges, exp_pos, prev_idx, dec, d, cur;
    logic [CW-1:0] exp_pos_v;
    logic [CW-1:0] sv;
    logic [PW-1:0] pv;
    logic [31:0]   rnd;
    logic [1:0]    exp_enc;
    logic          exp_done, exp_busy;
    n    = (steps < 0) ? -steps : steps;
    sgn  = (steps < 0) ? -1 : 1;
    p    = (period == 0) ? 1 : period;
    tend = (abort_e > 0) ? abort_e * p : n * p;
    sv = steps[CW-1:0];
    pv = period[PW-1:0];
    cmd_valid  = 1'b1;
    cmd_steps  = sv;
    cmd_period = pv;
    @(posedge clk);
    dec      = 0;
    prev_idx = m_ph;
    edges    = 0;
    for (int t = 0; t <= tend; t++) begin
      @(negedge clk);
      rnd        = $urandom;
      cmd_valid  = junk && (t < tend);
      cmd_steps  = rnd[CW-1:0];
      cmd_period = rnd[31:32-PW];
      abort      = (abort_e > 0) && (t == abort_e * p - 1);
      pos_clear  = (clear_e > 0) && (t == clear_e * p - 1);
      edges = t / p;
      if (abort_e > 0) begin
        if (edges > abort_e - 1) edges = abort_e - 1;
      end else begin
        if (edges > n) edges = n;
      end
      if (clear_e > 0 && edges >= clear_e) exp_pos = sgn * (edges - clear_e);
      else                                 exp_pos = m_pos + sgn * edges;
      exp_pos_v = exp_pos[CW-1:0];
      exp_enc   = gray_tab[(((m_ph + sgn * edges) % 4) + 4) % 4];
      exp_done  = (abort_e == 0) && (t == tend);
      exp_busy  = (t < tend);
      cur = gidx(enc);
      d   = (cur - prev_idx + 4) % 4;
      if (d == 1) dec++;
      if (d == 3) dec--;
      prev_idx = cur;
      total++;
      if (d == 2) begin
        bad++;
        $display("FAIL gray_step steps=%0d t=%0d enc=%b (two bits changed)", steps, t, enc);
      end
      total++;
      if (enc !== exp_enc) begin
        bad++;
        $display("FAIL enc steps=%0d per=%0d t=%0d got=%b exp=%b", steps, period, t, enc, exp_enc);
      end
      total++;
      if (position !== exp_pos_v) begin
        bad++;
        $display("FAIL position steps=%0d t=%0d got=%0d exp=%0d", steps, t,
                 $signed(position), $signed(exp_pos_v));
      end
      total++;
      if (done !== exp_done) begin
        bad++;
        $display("FAIL done steps=%0d t=%0d got=%b exp=%b", steps, t, done, exp_done);
      end
      total++;
      if (busy !== exp_busy || cmd_ready !== !exp_busy) begin
        bad++;
        $display("FAIL busy_ready steps=%0d t=%0d got busy=%b ready=%b exp busy=%b",
                 steps, t, busy, cmd_ready, exp_busy);
      end
    end
    total++;
    if (dec != sgn * edges) begin
      bad++;
      $display("FAIL decoded_moves steps=%0d got=%0d exp=%0d", steps, dec, sgn * edges);
    end
    m_pos = exp_pos;
    m_ph  = (((m_ph + sgn * edges) % 4) + 4) % 4;
  endtask

  task automatic idle_clear();
    pos_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pos_clear = 1'b0;
    m_pos = 0;
    total++;
    if (position !== {CW{1'b0}}) begin
      bad++;
      $display("FAIL idle_clear got=%0d exp=0", $signed(position));
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_steps  = {CW{1'b0}};
    cmd_period = {PW{1'b0}};
    abort      = 1'b0;
    pos_clear  = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (enc !== 2'b00 || position !== {CW{1'b0}} || done !== 1'b0 ||
        busy !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state got enc=%b pos=%0d done=%b busy=%b ready=%b exp 00/0/0/0/1",
               enc, position, done, busy, cmd_ready);
    end
    reset_n = 1'b1;
    @(negedge clk);
    m_pos = 0;
    m_ph  = 0;
  endtask

  task automatic test_basic();
    run_cmd(4, 3, 0, 0, 0);
    idle_clear();
    run_cmd(-3, 0, 0, 0, 0);
    total++;
    if ($signed(position) != -3) begin
      bad++;
      $display("FAIL minus3_position got=%0d exp=-3", $signed(position));
    end
    run_cmd(0, 5, 0, 0, 0);
  endtask

  task automatic test_abort();
    run_cmd(10, 2, 5, 0, 1);
    run_cmd(3, 1, 1, 0, 0);
    run_cmd(2, 4, 0, 0, 0);
  endtask

  task automatic test_pos_clear();
    run_cmd(6, 2, 0, 3, 0);
    run_cmd(-5, 1, 0, 5, 1);
  endtask

  task automatic test_wrap();
    idle_clear();
    run_cmd(16383, 1, 0, 0, 0);
    run_cmd(1, 2, 0, 0, 0);
    total++;
    if (position !== 15'h4000) begin
      bad++;
      $display("FAIL wrap got=%h exp=4000", position);
    end
    run_cmd(-16384, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back_random();
    int st, pe, ab, cl, n;
    bit jk;
    for (int i = 0; i < 40; i++) begin
      st = $urandom_range(40, 0) - 20;
      pe = $urandom_range(4, 0);
      n  = (st < 0) ? -st : st;
      ab = 0;
      cl = 0;
      if (n > 0 && $urandom_range(2, 0) == 0) ab = $urandom_range(n, 1);
      else if (n > 0 && $urandom_range(3, 0) == 0) cl = $urandom_range(n, 1);
      jk = $urandom_range(1, 0) == 1;
      run_cmd(st, pe, ab, cl, jk);
    end
  endtask

  task automatic test_reset_mid();
    cmd_valid  = 1'b1;
    cmd_steps  = 15'd20;
    cmd_period = 16'd2;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy got=%b exp=1", busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (enc !== 2'b00 || position !== {CW{1'b0}} || done !== 1'b0 ||
        busy !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid got enc=%b pos=%0d done=%b busy=%b ready=%b exp 00/0/0/0/1",
               enc, position, done, busy, cmd_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_pos = 0;
    m_ph  = 0;
    run_cmd(2, 1, 0, 0, 0);
  endtask

  initial begin
    gray_tab[0] = 2'b00;
    gray_tab[1] = 2'b01;
    gray_tab[2] = 2'b11;
    gray_tab[3] = 2'b10;
    test_reset();
    test_basic();
    test_abort();
    test_pos_clear();
    test_wrap();
    test_back_to_back_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bldc_quadrature_generator.md
# bldc_quadrature_generator

Synthesizes two-channel quadrature encoder waveforms from step commands, the transmit-side counterpart of the BLDC encoder counter. It sits in the BLDC test path and drives a counter's `enc` input directly for hardware-in-the-loop and self-test. It also keeps a signed running position that must always equal what a correct decoder accumulates from the emitted waveform.

## Interface

- `COUNT_WIDTH`, 15: width of the step command and of the position.
- `PERIOD_WIDTH`, 16: width of the clocks-per-edge command.
- `clk` input 1: system clock; all logic is on its rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `cmd_valid` input 1: a command is offered.
- `cmd_ready` output 1: the generator can accept a command; high only in IDLE.
- `cmd_steps` input COUNT_WIDTH: signed edge count. Positive is up, negative is down.
- `cmd_period` input PERIOD_WIDTH: clocks between edges, unsigned. 0 is treated as 1.
- `abort` input 1: synchronous stop of a running command.
- `pos_clear` input 1: synchronous clear of `position`.
- `enc` output 2: quadrature outputs, {A,B}, registered.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle pulse when a command completes normally.
- `position` output COUNT_WIDTH: signed running edge count.

## Operation

- **States:**
  - IDLE: `cmd_ready`=1, `busy`=0.
  - RUN: `cmd_ready`=0, `busy`=1.
- **Accept:** a command is accepted when `cmd_valid` && `cmd_ready` at a rising edge. On accept, latch:
  - `dir` = sign bit of `cmd_steps`.
  - `remaining` = |`cmd_steps`|, unsigned COUNT_WIDTH. -2^(COUNT_WIDTH-1) yields 2^(COUNT_WIDTH-1) with no overflow.
  - `period` = max(`cmd_period`, 1).
  - The timer is loaded with `period`.
- **Zero-step command:** if `cmd_steps` is 0, the state stays IDLE, no edges are emitted, and `done` pulses in the next cycle.
- **Sequence:**
  - Up steps 00→01→11→10→00.
  - Down steps 00→10→11→01→00.
  - Exactly one bit of `enc` changes per edge, so every emitted transition is Gray-valid.
- **Timer:** counts down once per clock while in RUN. At 1 it:
  - advances `enc` one step in `dir`,
  - updates `position` by ±1, wrapping modulo 2^COUNT_WIDTH,
  - decrements `remaining`,
  - reloads with `period`.
- **Completion:** when the edge that takes `remaining` to 0 is emitted, the state goes to IDLE and `done`=1 for exactly that cycle.
- **`abort`:** in RUN, the state goes to IDLE at the next edge. No further `enc` change occurs and `done` stays 0. `abort` is ignored in IDLE.
- **`abort` together with a due edge:** `abort` wins and no edge is emitted.
- **`pos_clear`:** `position` becomes 0. When it coincides with an edge, the clear wins (`position`=0) and `enc` still advances.
- **Idle hold:** `enc` holds its last value across commands, and sequence phase continues from it.
- **Unaccepted inputs:** command inputs are ignored while `cmd_ready`=0.

## Timing

- Reset values: `enc`=00, `position`=0, `done`=0, state IDLE, so `cmd_ready`=1 and `busy`=0 immediately after `reset_n` asserts.
- Accept at edge k: edge n (n=1..N) changes `enc` at edge k+n·period.
- `done` is high during the cycle following edge k+N·period.
- `cmd_ready` is high in that same cycle, so back-to-back commands have no dead cycle.
- `period`=1: `enc` changes every clock.
- `reset_n` asserted mid-RUN: all state returns to reset values immediately, with no partial `done`.
- `cmd_ready` and `busy` are decoded from the state register. All other outputs are registered.

## Structure

- **Shared package/include:**
  - Quadrature codes STEP_0..STEP_3 (00, 01, 10, 11). These are shared with the encoder counter.
  - State encodings IDLE and RUN.
  - A next-step function (code, dir) → code.
- **Sub-module `quad_step_timer`:**
  - Reloadable down-counter of PERIOD_WIDTH.
  - Inputs: `load`, `period`, `run`.
  - Output: one-cycle `tick` when the count reaches 1.
- The top level holds the FSM, `remaining`, `enc` and `position`.

## Test plan

- Reset, then steps=4, period=3 → `enc` goes 01, 11, 10, 00 at accept+3/6/9/12. `position`=4. `done` pulses once at accept+12. `busy` is low afterwards.
- steps=-3, period=0 → `enc` goes 10, 11, 01 on three consecutive clocks. `position`=-3. A counter instance fed by `enc` reads -3.
- steps=0 → no `enc` change and `busy` never high. `done` is high in the cycle after accept.
- steps=10, period=2, `abort` asserted on the cycle the 5th edge is due → exactly 4 edges and `position`=4. No `done`. `cmd_ready` is high next cycle.
- `position` at 2^(COUNT_WIDTH-1)-1, steps=1 → `position` wraps to -2^(COUNT_WIDTH-1).
- `pos_clear` coincident with an edge → `position`=0 and `enc` advances.
- `reset_n` low mid-command → `enc`=00 and `position`=0 immediately.
